// File: rtl/mem_arbiter.sv
// mem_arbiter: boot sequencer plus fetch/data arbiter for a single-port RAM.
// All RAM control outputs come straight from flops so the level-sensitive
// RAM write never sees a glitching address or data bus.
//
// state  | meaning
// -------+-------------------------------------------------------------
// BOOT   | ram_start high, counting BOOT_CYCLES, requests ignored
// IDLE   | requests sampled, grant decided, address/data latched
// ACCESS | ram_r or ram_w high, read data captured at end of cycle
// RESP   | one-cycle ack to the granted port
module mem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int BOOT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              ram_r,
  output logic              ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_start,
  output logic              busy
);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_boot_cnt;
  logic [2:0]        r_streak;
  logic              r_src_d;
  logic              r_we;
  logic              r_ram_r;
  logic              r_ram_w;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ack;
  logic              r_d_ack;

  logic              w_boot_done;
  logic              w_starved;
  logic              w_grant_d;
  logic              w_grant_if;

  assign w_boot_done = (r_boot_cnt == 4'(BOOT_CYCLES - 1));
  // Fetch only wins a contested cycle once data has taken STARVE_LIMIT in a row.
  assign w_starved   = (r_streak == 3'(STARVE_LIMIT));
  assign w_grant_d   = (r_state == S_IDLE) && d_req && !(if_req && w_starved);
  assign w_grant_if  = (r_state == S_IDLE) && if_req && !w_grant_d;

  // State register.
  always_ff @(posedge clock) begin
    if (clear) r_state <= S_BOOT;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:   if (w_boot_done) w_next_state = S_IDLE;
      S_IDLE:   if (w_grant_d || w_grant_if) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = S_RESP;
      S_RESP:   w_next_state = S_IDLE;
      default:  w_next_state = S_BOOT;
    endcase
  end

  // Boot counter: runs only while in BOOT, parked at zero otherwise.
  always_ff @(posedge clock) begin
    if (clear)                                 r_boot_cnt <= '0;
    else if (r_state == S_BOOT && !w_boot_done) r_boot_cnt <= r_boot_cnt + 4'd1;
    else                                       r_boot_cnt <= '0;
  end

  // Grant latching, RAM strobes, read-data capture, acks and starvation streak.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_src_d    <= 1'b0;
      r_we       <= 1'b0;
      r_ram_r    <= 1'b0;
      r_ram_w    <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_streak   <= '0;
    end else begin
      r_ram_r  <= 1'b0;
      r_ram_w  <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;

      if (w_grant_d || w_grant_if) begin
        r_src_d    <= w_grant_d;
        r_we       <= w_grant_d && d_we;
        r_ram_addr <= w_grant_d ? d_addr : if_addr;
        if (w_grant_d && d_we) r_ram_din <= d_wdata;
        r_ram_r    <= w_grant_if || (w_grant_d && !d_we);
        r_ram_w    <= w_grant_d && d_we;
      end

      if (r_state == S_ACCESS) begin
        if (!r_we) begin
          if (r_src_d) r_d_rdata  <= ram_dout;
          else         r_if_rdata <= ram_dout;
        end
        r_d_ack  <= r_src_d;
        r_if_ack <= !r_src_d;
      end

      if (w_grant_d) begin
        if (!if_req)         r_streak <= '0;
        else if (!w_starved) r_streak <= r_streak + 3'd1;
      end else if (w_grant_if) begin
        r_streak <= '0;
      end
    end
  end

  assign ram_r     = r_ram_r;
  assign ram_w     = r_ram_w;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign ram_start = (r_state == S_BOOT);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 512 x 32 RAM that reloads
// its preload image whenever ram_start is high.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic        if_req;
  logic [8:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        ram_r;
  logic        ram_w;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_start;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] mem [512];
  logic        both_seen = 1'b0;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .BOOT_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_r(ram_r), .ram_w(ram_w), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_start(ram_start), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM model: preload image while ram_start, otherwise write on ram_w.
  always @(posedge clock) begin
    if (ram_start) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[9'h000] <= 32'h0980_0065;
      mem[9'h001] <= 32'h0998_0003;
      mem[9'h054] <= 32'h0000_0097;
      mem[9'h092] <= 32'h0000_0046;
    end else if (ram_w) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  always @(negedge clock) if (ram_r && ram_w) both_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts ram_start-high cycles from the current negedge; stops at first low.
  task automatic count_boot(output int cnt, output logic dack_seen);
    cnt = 0;
    dack_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (d_ack) dack_seen = 1'b1;
      if (!ram_start) break;
      cnt++;
      @(negedge clock);
    end
  endtask

  // One request on one port; returns at the negedge of its ack (or timeout).
  task automatic access(input logic is_d, input logic we, input logic [8:0] addr,
                        input logic [31:0] wdata, output logic ok,
                        output logic [31:0] rdata, output int n_w, output int n_r,
                        output logic [8:0] addr_seen, output logic other_ack);
    ok = 1'b0; rdata = '0; n_w = 0; n_r = 0; addr_seen = '0; other_ack = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (ram_w) n_w++;
      if (ram_r) n_r++;
      if (ram_w || ram_r) addr_seen = ram_addr;
      if (is_d ? if_ack : d_ack) other_ack = 1'b1;
      if (is_d ? d_ack : if_ack) begin
        ok = 1'b1;
        rdata = is_d ? d_rdata : if_rdata;
      end
    end
    d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    int          cnt;
    logic        dseen;
    logic        ok;
    logic [31:0] rd;
    int          nw, nr;
    logic [8:0]  aseen;
    logic        oack;
    int          d_cyc, f_cyc, nacks;
    logic [31:0] d_val, f_val;
    logic [9:0]  ord;

    clear = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_ram_start", 32'(ram_start), 32'd1);
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_ram_rw",    {30'd0, ram_r, ram_w}, 32'd0);
    check("rst_acks",      {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_din",   ram_din,        32'd0);
    check("rst_if_rdata",  if_rdata,       32'd0);
    check("rst_d_rdata",   d_rdata,        32'd0);

    // Boot length after clear falls
    clear = 1'b0;
    count_boot(cnt, dseen);
    check("boot_cycles", 32'(cnt), 32'd2);
    check("idle_busy",   32'(busy), 32'd0);

    // First fetch from 0x000, stepped cycle by cycle
    if_req = 1'b1; if_addr = 9'h000;
    @(negedge clock);
    check("f0_access_ram_r", 32'(ram_r), 32'd1);
    check("f0_access_addr",  32'(ram_addr), 32'h000);
    check("f0_access_noack", 32'(if_ack), 32'd0);
    @(negedge clock);
    check("f0_resp_ack",    32'(if_ack), 32'd1);
    check("f0_resp_rdata",  if_rdata, 32'h0980_0065);
    check("f0_resp_ram_r",  32'(ram_r), 32'd0);
    if_req = 1'b0;
    @(negedge clock);
    check("f0_ack_pulse",   32'(if_ack), 32'd0);

    // Data write then read at 0x1A2
    access(1'b1, 1'b1, 9'h1A2, 32'hDEAD_BEEF, ok, rd, nw, nr, aseen, oack);
    check("wr_ack",        32'(ok), 32'd1);
    check("wr_ram_w_cyc",  32'(nw), 32'd1);
    check("wr_ram_r_cyc",  32'(nr), 32'd0);
    check("wr_addr",       32'(aseen), 32'h1A2);
    check("wr_rdata_hold", rd, 32'h0);
    check("wr_din",        ram_din, 32'hDEAD_BEEF);
    check("wr_no_if_ack",  32'(oack), 32'd0);
    access(1'b1, 1'b0, 9'h1A2, 32'h0, ok, rd, nw, nr, aseen, oack);
    check("rd_ack",        32'(ok), 32'd1);
    check("rd_data",       rd, 32'hDEAD_BEEF);
    check("rd_ram_w_cyc",  32'(nw), 32'd0);
    check("rd_no_if_ack",  32'(oack), 32'd0);

    // Top address boundary
    access(1'b1, 1'b1, 9'h1FF, 32'hA5A5_5A5A, ok, rd, nw, nr, aseen, oack);
    check("wr1ff_addr", 32'(aseen), 32'h1FF);
    access(1'b1, 1'b0, 9'h1FF, 32'h0, ok, rd, nw, nr, aseen, oack);
    check("rd1ff_data", rd, 32'hA5A5_5A5A);

    // Simultaneous requests: data first, fetch 3 cycles later
    @(negedge clock);
    if_req = 1'b1; if_addr = 9'h054;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h092;
    d_cyc = -1; f_cyc = -1; d_val = '0; f_val = '0;
    for (int i = 0; i < 20 && (d_cyc < 0 || f_cyc < 0); i++) begin
      @(negedge clock);
      if (d_ack) begin d_cyc = i; d_val = d_rdata; d_req = 1'b0; end
      if (if_ack) begin f_cyc = i; f_val = if_rdata; if_req = 1'b0; end
    end
    check("both_d_rdata",  d_val, 32'h0000_0046);
    check("both_if_rdata", f_val, 32'h0000_0097);
    check("both_d_cycle",  32'(d_cyc), 32'd1);
    check("both_f_cycle",  32'(f_cyc), 32'd4);

    // Starvation: both held continuously
    @(negedge clock);
    if_req = 1'b1; if_addr = 9'h001;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h000;
    ord = '0; nacks = 0;
    for (int i = 0; i < 80 && nacks < 10; i++) begin
      @(negedge clock);
      if (d_ack)  begin ord = {ord[8:0], 1'b0}; nacks++; end
      if (if_ack) begin ord = {ord[8:0], 1'b1}; nacks++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve_nacks", 32'(nacks), 32'd10);
    check("starve_order", 32'(ord), 32'(10'b0000100001));
    check("never_r_and_w", 32'(both_seen), 32'd0);

    // Clear during the ACCESS cycle of a data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 9'h010; d_wdata = 32'h1234_5678;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (ram_w) ok = 1'b1;
    end
    check("abort_reached_access", 32'(ok), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    check("abort_ram_w_drop", 32'(ram_w), 32'd0);
    check("abort_no_d_ack",   32'(d_ack), 32'd0);
    check("abort_ram_start",  32'(ram_start), 32'd1);
    clear = 1'b0; d_req = 1'b0; d_we = 1'b0;
    count_boot(cnt, dseen);
    check("reboot_cycles",   32'(cnt), 32'd2);
    check("reboot_no_d_ack", 32'(dseen), 32'd0);
    access(1'b0, 1'b0, 9'h001, 32'h0, ok, rd, nw, nr, aseen, oack);
    check("reboot_fetch_ack",  32'(ok), 32'd1);
    check("reboot_fetch_data", rd, 32'h0998_0003);
    check("reboot_fetch_no_w", 32'(nw), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
